// File: rtl/jpu_pkg.sv
// rtl/jpu_pkg.sv - shared JPU constants and fetch state encoding
// Purpose : instruction width, fetch FSM state type and default reset PC
//           shared by jpu_fetch and jpu_pc_counter.
// Ports   : none (package).
package jpu_pkg;

   localparam int INSTR_W = 16;

   // Default reset PC for the fetch stage.
   localparam int unsigned DEFAULT_RESET_PC = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/jpu_pc_counter.sv
// rtl/jpu_pc_counter.sv - JPU program counter register
// Purpose : ADDR_W-wide PC with a load (branch) and a wrap-around increment.
//           The load input has priority over the increment input.
// Ports   : clk, reset        clock, asynchronous active-high reset
//           load, load_value  load pc with load_value
//           incr              pc <= pc + 1 (modulo 2^ADDR_W)
//           pc                current program counter
module jpu_pc_counter
   import jpu_pkg::*;
#(
   parameter int          ADDR_W   = 8,
   parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_value,
   input  logic              incr,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= ADDR_W'(RESET_PC);
      end else if (load) begin
         pc <= load_value;
      end else if (incr) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/jpu_fetch.sv
// rtl/jpu_fetch.sv - JPU instruction fetch stage
// Purpose : holds the PC, issues req/ack reads to instruction memory and
//           registers each word for the decoder; handles decoder stall and
//           execute-stage branch redirects.
// Option  : JPU_FETCH_PERF_EN adds fetch_count (saturating consumed-word count).
// Ports   : clk, reset                      clock, asynchronous active-high reset
//           enable                          allow new fetches to start
//           stall                           decoder not ready
//           branch_en, branch_target        one-cycle redirect request and target
//           mem_req, mem_addr               read request / address to memory
//           mem_ack, mem_rdata              read completion and data
//           instruction, instr_valid, pc_out  registered word to decoder
//           fetch_count                     (option) consumed words, saturating
module jpu_fetch
   import jpu_pkg::*;
#(
   parameter int          ADDR_W   = 8,
   parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               stall,
   input  logic               branch_en,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc_out
`ifdef JPU_FETCH_PERF_EN
   ,
   output logic [15:0]        fetch_count
`endif
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] drain_addr;
   logic              pc_load;
   logic              pc_incr;

   // Every state accepts a redirect; only a clean capture in FETCH advances.
   always_comb begin
      pc_load = branch_en;
      pc_incr = 1'b0;
      if (state == ST_FETCH && mem_ack && !branch_en) begin
         pc_incr = 1'b1;
      end
   end

   jpu_pc_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk        (clk),
      .reset      (reset),
      .load       (pc_load),
      .load_value (branch_target),
      .incr       (pc_incr),
      .pc         (pc)
   );

   // pc already points at the branch target while draining, so the
   // abandoned read keeps its own copy of the address.
   assign mem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
   assign mem_addr = (state == ST_DRAIN) ? drain_addr : pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         drain_addr  <= '0;
         instruction <= '0;
         instr_valid <= 1'b0;
         pc_out      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable) state <= ST_FETCH;
            end
            ST_FETCH: begin
               if (mem_ack) begin
                  // A redirect on the ack cycle drops the word and re-requests.
                  if (!branch_en) begin
                     instruction <= mem_rdata;
                     pc_out      <= pc;
                     instr_valid <= 1'b1;
                     state       <= ST_HOLD;
                  end
               end else if (branch_en) begin
                  drain_addr <= pc;
                  state      <= ST_DRAIN;
               end
            end
            ST_HOLD: begin
               if (branch_en || !stall) begin
                  instr_valid <= 1'b0;
                  state       <= enable ? ST_FETCH : ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (mem_ack) state <= enable ? ST_FETCH : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef JPU_FETCH_PERF_EN
   // A word squashed by a coincident branch is not counted as consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count <= '0;
      end else if (instr_valid && !stall && !branch_en && fetch_count != 16'hFFFF) begin
         fetch_count <= fetch_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_jpu_fetch.sv
// tb/tb_jpu_fetch.sv - self-checking bench for jpu_fetch
module tb_jpu_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable, stall, branch_en, mem_ack;
   logic [7:0]  branch_target;
   logic [15:0] mem_rdata;
   logic        mem_req, instr_valid;
   logic [7:0]  mem_addr, pc_out;
   logic [15:0] instruction;
`ifdef JPU_FETCH_PERF_EN
   logic [15:0] fetch_count;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model: an outstanding read (busy/discard/raddr), a held word,
   // the next PC and the consumed-word count.
   logic        m_busy, m_discard, m_valid;
   logic [7:0]  m_raddr, m_pc, m_pcout;
   logic [15:0] m_instr, m_count;

   always #5 clk = ~clk;

   jpu_fetch #(.ADDR_W(8), .RESET_PC(0)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .stall         (stall),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .instruction   (instruction),
      .instr_valid   (instr_valid),
      .pc_out        (pc_out)
`ifdef JPU_FETCH_PERF_EN
      ,
      .fetch_count   (fetch_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_discard = 0; m_valid = 0;
      m_raddr = 0; m_pc = 0; m_pcout = 0; m_instr = 0; m_count = 0;
   endtask

   task automatic start_read();
      m_busy = 1; m_discard = 0; m_raddr = m_pc;
   endtask

   task automatic model_step(input logic en, input logic st, input logic br,
                             input logic [7:0] tgt, input logic ack, input logic [15:0] rd);
      if (m_valid && !st && !br && m_count != 16'hFFFF) m_count = m_count + 16'd1;
      if (m_valid) begin
         if (br) m_pc = tgt;
         if (br || !st) begin
            m_valid = 0;
            if (en) start_read();
         end
      end else if (m_busy) begin
         if (ack) begin
            m_busy = 0;
            if (br) m_pc = tgt;
            if (!m_discard && !br) begin
               m_valid = 1; m_instr = rd; m_pcout = m_raddr;
               m_pc = 8'(m_raddr + 8'd1);
            end else if (!m_discard || en) begin
               start_read();
            end
         end else if (br) begin
            m_pc = tgt;
            m_discard = 1;
         end
      end else begin
         if (br) m_pc = tgt;
         if (en) start_read();
      end
   endtask

   task automatic cmp_model();
      chk("model mem_req", {31'b0, mem_req}, {31'b0, m_busy});
      if (m_busy) chk("model mem_addr", {24'b0, mem_addr}, {24'b0, m_raddr});
      chk("model instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("model instruction", {16'b0, instruction}, {16'b0, m_instr});
      chk("model pc_out", {24'b0, pc_out}, {24'b0, m_pcout});
`ifdef JPU_FETCH_PERF_EN
      chk("model fetch_count", {16'b0, fetch_count}, {16'b0, m_count});
`endif
   endtask

   // Drive one cycle of inputs, advance past the edge and compare to the model.
   task automatic cycle(input logic en, input logic st, input logic br,
                        input logic [7:0] tgt, input logic ack, input logic [15:0] rd);
      enable = en; stall = st; branch_en = br; branch_target = tgt;
      mem_ack = ack; mem_rdata = rd;
      @(posedge clk);
      #1;
      model_step(en, st, br, tgt, ack, rd);
      cmp_model();
   endtask

   typedef struct {
      logic        en, st, br;
      logic [7:0]  tgt;
      logic        ack;
      logic [15:0] rd;
      logic        e_req;
      logic [7:0]  e_addr;
      logic        e_valid;
      logic [15:0] e_instr;
      logic [7:0]  e_pcout;
   } vec_t;

   vec_t vecs[13];

   initial begin
      // en st br tgt ack rdata | req addr valid instr pc_out
      vecs[0]  = '{1,0,0,8'h00,0,16'h0000, 1,8'h00,0,16'h0000,8'h00};
      vecs[1]  = '{1,0,0,8'h00,1,16'hF342, 0,8'h00,1,16'hF342,8'h00};
      vecs[2]  = '{1,0,0,8'h00,0,16'h0000, 1,8'h01,0,16'hF342,8'h00};
      vecs[3]  = '{1,1,0,8'h00,1,16'h3412, 0,8'h00,1,16'h3412,8'h01};
      vecs[4]  = '{1,1,0,8'h00,0,16'h0000, 0,8'h00,1,16'h3412,8'h01};
      vecs[5]  = '{1,1,0,8'h00,0,16'h0000, 0,8'h00,1,16'h3412,8'h01};
      vecs[6]  = '{1,1,0,8'h00,0,16'h0000, 0,8'h00,1,16'h3412,8'h01};
      vecs[7]  = '{1,0,0,8'h00,0,16'h0000, 1,8'h02,0,16'h3412,8'h01};
      vecs[8]  = '{1,0,1,8'hFF,1,16'hDEAD, 1,8'hFF,0,16'h3412,8'h01};
      vecs[9]  = '{1,0,0,8'h00,1,16'h00FF, 0,8'h00,1,16'h00FF,8'hFF};
      vecs[10] = '{0,0,0,8'h00,0,16'h0000, 0,8'h00,0,16'h00FF,8'hFF};
      vecs[11] = '{1,0,0,8'h00,0,16'h0000, 1,8'h00,0,16'h00FF,8'hFF};
      vecs[12] = '{1,0,0,8'h00,1,16'h1111, 0,8'h00,1,16'h1111,8'h00};

      reset = 1; enable = 0; stall = 0; branch_en = 0; branch_target = 0;
      mem_ack = 0; mem_rdata = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset mem_req", {31'b0, mem_req}, 32'd0);
      chk("reset instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("reset instruction", {16'b0, instruction}, 32'd0);
      chk("reset pc_out", {24'b0, pc_out}, 32'd0);
      reset = 0;

      // Table vectors: first fetch, stall hold, branch+ack, PC wrap.
      for (int i = 0; i < 13; i++) begin
         cycle(vecs[i].en, vecs[i].st, vecs[i].br, vecs[i].tgt, vecs[i].ack, vecs[i].rd);
         chk($sformatf("vec%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_req});
         if (vecs[i].e_req)
            chk($sformatf("vec%0d mem_addr", i), {24'b0, mem_addr}, {24'b0, vecs[i].e_addr});
         chk($sformatf("vec%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
         chk($sformatf("vec%0d instruction", i), {16'b0, instruction}, {16'b0, vecs[i].e_instr});
         chk($sformatf("vec%0d pc_out", i), {24'b0, pc_out}, {24'b0, vecs[i].e_pcout});
      end

      // Branch while a read is outstanding: drain, stale word never valid.
      cycle(1, 0, 0, 8'h00, 0, 16'h0000);
      cycle(1, 0, 1, 8'h40, 0, 16'h0000);
      chk("drain mem_req", {31'b0, mem_req}, 32'd1);
      chk("drain mem_addr", {24'b0, mem_addr}, 32'h01);
      cycle(1, 0, 0, 8'h00, 0, 16'h0000);
      chk("drain hold addr", {24'b0, mem_addr}, 32'h01);
      cycle(1, 0, 0, 8'h00, 1, 16'h7801);
      chk("drain discard valid", {31'b0, instr_valid}, 32'd0);
      chk("drain next addr", {24'b0, mem_addr}, 32'h40);
      cycle(1, 0, 0, 8'h00, 1, 16'h4040);
      chk("target instruction", {16'b0, instruction}, 32'h4040);
      chk("target pc_out", {24'b0, pc_out}, 32'h40);

      // Branch coincident with consume in HOLD.
      cycle(1, 0, 1, 8'h80, 0, 16'h0000);
      chk("hold branch valid", {31'b0, instr_valid}, 32'd0);
      chk("hold branch addr", {24'b0, mem_addr}, 32'h80);
      cycle(1, 0, 0, 8'h00, 1, 16'h8080);
      chk("hold branch pc_out", {24'b0, pc_out}, 32'h80);

      // Reset mid-read, then a late ack while idle.
      cycle(1, 0, 0, 8'h00, 0, 16'h0000);
      cycle(1, 0, 0, 8'h00, 0, 16'h0000);
      #2 reset = 1;
      #1;
      model_reset();
      chk("async reset mem_req", {31'b0, mem_req}, 32'd0);
      chk("async reset instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("async reset instruction", {16'b0, instruction}, 32'd0);
      chk("async reset pc_out", {24'b0, pc_out}, 32'd0);
      @(posedge clk);
      #1 reset = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 8'h00, 1, 16'hBEEF);
         chk("late ack valid", {31'b0, instr_valid}, 32'd0);
         chk("late ack mem_req", {31'b0, mem_req}, 32'd0);
      end

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(3) != 0), ($urandom_range(2) == 0), ($urandom_range(7) == 0),
               8'($urandom), ($urandom_range(1) == 1), 16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
